// File: rtl/noc_input_port_buffer_if.sv
// Signal bundle for one router input port: upstream RTS/DCTS link,
// per-direction request/grant pairs and FIFO status.
interface noc_input_port_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                       RTS;
    logic [DATA_W-1:0]          rx_flit;
    logic                       DCTS;
    logic                       Req_N, Req_E, Req_W, Req_S, Req_L;
    logic                       Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
    logic [DATA_W-1:0]          dout;
    logic                       empty;
    logic [$clog2(DEPTH):0]     occupancy;
    logic                       err;

    // slave: the input port buffer itself
    modport slave (
        input  RTS, rx_flit, Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
        output DCTS, Req_N, Req_E, Req_W, Req_S, Req_L, dout, empty, occupancy, err
    );

    // master: upstream link plus the local output arbiters
    modport master (
        output RTS, rx_flit, Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
        input  DCTS, Req_N, Req_E, Req_W, Req_S, Req_L, dout, empty, occupancy, err
    );
endinterface

// File: rtl/noc_input_port_buffer.sv
// Router input port: RTS/DCTS receive handshake into a small FIFO, with an
// XY-routed one-hot request held from head flit to tail flit.
module noc_input_port_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    noc_input_port_buffer_if.slave   link
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [2:0] TYPE_HEAD = 3'b001;
    localparam logic [2:0] TYPE_TAIL = 3'b100;
    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

    // Request/grant vectors are packed {N, E, W, S, L}
    localparam logic [4:0] DIR_N = 5'b10000;
    localparam logic [4:0] DIR_E = 5'b01000;
    localparam logic [4:0] DIR_W = 5'b00100;
    localparam logic [4:0] DIR_S = 5'b00010;
    localparam logic [4:0] DIR_L = 5'b00001;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("noc_input_port_buffer: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               dcts_q, err_q;
    logic [4:0]         req_q;
    state_t             state;

    logic               empty, accept, pop, err_next;
    logic [DATA_W-1:0]  head_flit;
    logic [2:0]         head_type;
    logic [COORD_W-1:0] dest_x, dest_y;
    logic [4:0]         grant, route_req;

    assign empty     = (occ == '0);
    assign head_flit = mem[rd_ptr];
    assign head_type = head_flit[DATA_W-1 -: 3];
    assign dest_x    = head_flit[COORD_W-1:0];
    assign dest_y    = head_flit[2*COORD_W-1:COORD_W];
    assign grant     = {link.Grant_N, link.Grant_E, link.Grant_W, link.Grant_S, link.Grant_L};

    // Fullness uses registered occupancy: a same-cycle pop does not free a slot.
    assign accept = link.RTS & ~dcts_q & (occ < OCC_W'(DEPTH));

    // XY routing: resolve X first, then Y, then deliver locally.
    always_comb begin
        route_req = DIR_L;
        if (dest_x > CX)      route_req = DIR_E;
        else if (dest_x < CX) route_req = DIR_W;
        else if (dest_y < CY) route_req = DIR_N;
        else if (dest_y > CY) route_req = DIR_S;
    end

    always_comb begin
        pop      = 1'b0;
        err_next = 1'b0;
        case (state)
            IDLE: begin
                // Orphan body/tail flits with no preceding head are dropped.
                if (!empty && head_type != TYPE_HEAD) begin
                    pop      = 1'b1;
                    err_next = 1'b1;
                end
            end
            ACTIVE: begin
                pop      = ~empty & |(grant & req_q);
                err_next = |(grant & ~req_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem[wr_ptr] <= link.rx_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            dcts_q <= 1'b0;
            err_q  <= 1'b0;
            req_q  <= '0;
            state  <= IDLE;
        end else begin
            dcts_q <= accept;
            err_q  <= err_next;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (!empty && head_type == TYPE_HEAD) begin
                        req_q <= route_req;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop && head_type == TYPE_TAIL) begin
                        req_q <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign link.DCTS      = dcts_q;
    assign link.err       = err_q;
    assign link.occupancy = occ;
    assign link.empty     = empty;
    assign link.dout      = empty ? '0 : head_flit;
    assign {link.Req_N, link.Req_E, link.Req_W, link.Req_S, link.Req_L} = req_q;
endmodule

// File: tb/tb_noc_input_port_buffer.sv
// Directed bench: per-cycle vector table on a CUR=(0,0) port, plus short
// sequences for draining, S routing and W/N routing on a CUR=(1,1) port.
module tb_noc_input_port_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_input_port_buffer_if #(.DATA_W(32), .DEPTH(4)) if0();
    noc_input_port_buffer_if #(.DATA_W(32), .DEPTH(4)) if1();

    noc_input_port_buffer #(.DATA_W(32), .DEPTH(4), .COORD_W(2), .CUR_X(0), .CUR_Y(0))
        dut0 (.clk(clk), .rst(rst), .link(if0));
    noc_input_port_buffer #(.DATA_W(32), .DEPTH(4), .COORD_W(2), .CUR_X(1), .CUR_Y(1))
        dut1 (.clk(clk), .rst(rst), .link(if1));

    typedef struct {
        logic        rst;
        logic        rts;
        logic [31:0] flit;
        logic [4:0]  gnt;
        logic        dcts;
        logic [4:0]  req;
        logic [2:0]  occ;
        logic        err;
        logic [31:0] dout;
    } vec_t;

    // {N,E,W,S,L}
    localparam logic [4:0] N = 5'b10000, E = 5'b01000, W = 5'b00100, S = 5'b00010, L = 5'b00001;
    localparam logic [31:0] H  = 32'h2000_0001;  // head, dest (1,0)
    localparam logic [31:0] B1 = 32'h4000_0011;
    localparam logic [31:0] B2 = 32'h4000_0021;
    localparam logic [31:0] T  = 32'h8000_0031;
    localparam logic [31:0] H2 = 32'h2000_0000;  // head, dest (0,0)
    localparam logic [31:0] T2 = 32'h8000_0042;
    localparam logic [31:0] B3 = 32'h4000_0055;

    int errors = 0;
    int checks = 0;
    vec_t vt[$];

    function automatic vec_t mk(logic r, logic rts, logic [31:0] f, logic [4:0] g,
                                logic d, logic [4:0] q, logic [2:0] o, logic e, logic [31:0] dt);
        vec_t v;
        v.rst = r; v.rts = rts; v.flit = f; v.gnt = g;
        v.dcts = d; v.req = q; v.occ = o; v.err = e; v.dout = dt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] req0();
        return {if0.Req_N, if0.Req_E, if0.Req_W, if0.Req_S, if0.Req_L};
    endfunction

    function automatic logic [4:0] req1();
        return {if1.Req_N, if1.Req_E, if1.Req_W, if1.Req_S, if1.Req_L};
    endfunction

    task automatic push0(logic [31:0] f);
        if0.RTS = 1'b1; if0.rx_flit = f; step();
        if0.RTS = 1'b0; step();
    endtask

    task automatic push1(logic [31:0] f);
        if1.RTS = 1'b1; if1.rx_flit = f; step();
        if1.RTS = 1'b0; step();
    endtask

    initial begin
        logic [31:0] pkt[4];
        pkt[0] = H; pkt[1] = B1; pkt[2] = B2; pkt[3] = T;

        rst = 1'b1;
        if0.RTS = 0; if0.rx_flit = '0;
        {if0.Grant_N, if0.Grant_E, if0.Grant_W, if0.Grant_S, if0.Grant_L} = '0;
        if1.RTS = 0; if1.rx_flit = '0;
        {if1.Grant_N, if1.Grant_E, if1.Grant_W, if1.Grant_S, if1.Grant_L} = '0;

        //           rst rts flit gnt   dcts req occ err dout
        vt.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));   // reset state
        vt.push_back(mk(0, 1, H,  0, 1, 0, 1, 0, H));   // accept head
        vt.push_back(mk(0, 1, H,  0, 0, E, 1, 0, H));   // DCTS drops, Req_E
        vt.push_back(mk(0, 1, B1, 0, 1, E, 2, 0, H));
        vt.push_back(mk(0, 1, B1, 0, 0, E, 2, 0, H));
        vt.push_back(mk(0, 1, B2, 0, 1, E, 3, 0, H));
        vt.push_back(mk(0, 1, B2, 0, 0, E, 3, 0, H));
        vt.push_back(mk(0, 1, T,  0, 1, E, 4, 0, H));
        vt.push_back(mk(0, 1, T,  0, 0, E, 4, 0, H));   // full
        vt.push_back(mk(0, 1, H2, 0, 0, E, 4, 0, H));   // 5th RTS held off
        vt.push_back(mk(0, 1, H2, 0, 0, E, 4, 0, H));
        vt.push_back(mk(0, 1, H2, E, 0, E, 3, 0, B1));  // pop frees a slot, no same-cycle write
        vt.push_back(mk(0, 1, H2, 0, 1, E, 4, 0, B1));  // DCTS one cycle after the pop
        vt.push_back(mk(0, 1, H2, E, 0, E, 3, 0, B2));
        vt.push_back(mk(0, 0, 0,  E, 0, E, 2, 0, T));
        vt.push_back(mk(0, 0, 0,  E, 0, 0, 1, 0, H2));  // tail pop drops Req, rd_ptr wrapped
        vt.push_back(mk(0, 0, 0,  0, 0, L, 1, 0, H2));  // next packet to local
        vt.push_back(mk(0, 0, 0,  N, 0, L, 1, 1, H2));  // stray grant: no pop, err
        vt.push_back(mk(0, 1, T2, 0, 1, L, 2, 0, H2));
        vt.push_back(mk(0, 0, 0,  L, 0, L, 1, 0, T2));
        vt.push_back(mk(0, 0, 0,  L, 0, 0, 0, 0, 0));   // drained
        vt.push_back(mk(0, 0, 0,  E, 0, 0, 0, 0, 0));   // grant while IDLE: no err
        vt.push_back(mk(0, 1, B3, 0, 1, 0, 1, 0, B3));  // orphan body arrives
        vt.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 0));   // discarded with err
        vt.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, H,  0, 1, 0, 1, 0, H));
        vt.push_back(mk(1, 1, H,  0, 0, 0, 0, 0, 0));   // reset during DCTS
        vt.push_back(mk(0, 1, H,  0, 1, 0, 1, 0, H));   // fresh accept
        vt.push_back(mk(0, 0, 0,  0, 0, E, 1, 0, H));

        foreach (vt[i]) begin
            rst        = vt[i].rst;
            if0.RTS    = vt[i].rts;
            if0.rx_flit = vt[i].flit;
            {if0.Grant_N, if0.Grant_E, if0.Grant_W, if0.Grant_S, if0.Grant_L} = vt[i].gnt;
            step();
            chk($sformatf("v%0d dcts", i),  32'(if0.DCTS),      32'(vt[i].dcts));
            chk($sformatf("v%0d req", i),   32'(req0()),        32'(vt[i].req));
            chk($sformatf("v%0d occ", i),   32'(if0.occupancy), 32'(vt[i].occ));
            chk($sformatf("v%0d empty", i), 32'(if0.empty),     32'(vt[i].occ == 3'd0));
            chk($sformatf("v%0d err", i),   32'(if0.err),       32'(vt[i].err));
            chk($sformatf("v%0d dout", i),  if0.dout,           vt[i].dout);
        end
        if0.RTS = 0;
        {if0.Grant_N, if0.Grant_E, if0.Grant_W, if0.Grant_S, if0.Grant_L} = '0;

        // Full packet drained by Grant_E held for four consecutive cycles
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) push0(pkt[i]);
        chk("drain occ", 32'(if0.occupancy), 32'd4);
        chk("drain req", 32'(req0()), 32'(E));
        if0.Grant_E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain dout%0d", i), if0.dout, pkt[i]);
            step();
            chk($sformatf("drain req%0d", i), 32'(req0()), (i < 3) ? 32'(E) : 32'd0);
        end
        if0.Grant_E = 1'b0;
        chk("drain empty", 32'(if0.empty), 32'd1);

        // dest (0,1) from (0,0) goes south
        rst = 1'b1; step(); rst = 1'b0;
        push0(32'h2000_0004);
        chk("route S", 32'(req0()), 32'(S));

        // From (1,1): dest (0,0) resolves X first -> W; dest (1,0) -> N
        rst = 1'b1; step(); rst = 1'b0;
        push1(32'h2000_0000);
        chk("route W", 32'(req1()), 32'(W));
        push1(T2);
        if1.Grant_W = 1'b1; step(); step(); if1.Grant_W = 1'b0;
        chk("W drained req", 32'(req1()), 32'd0);
        chk("W drained empty", 32'(if1.empty), 32'd1);
        push1(32'h2000_0001);
        chk("route N", 32'(req1()), 32'(N));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_input_port_buffer.md
Name: noc_input_port_buffer

Overview:
- Receiving end of the router-to-router RTS/DCTS link. The upstream output-port arbiter raises RTS with a flit; this block answers with a one-cycle DCTS pulse and captures the flit.
- Flits are stored in a small FIFO. The head flit is XY-routed into a one-hot request (Req_N/E/W/S/L) towards the local output-port arbiters.
- Each matching Grant pops one flit. The request is held from the head flit until the tail flit leaves.

Parameters:
- DATA_W, 32, flit width; bits [DATA_W-1:DATA_W-3] are the flit type.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- COORD_W, 2, width of each destination coordinate.
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- RTS  in  1  upstream request-to-send; rx_flit is stable while RTS=1
- rx_flit  in  DATA_W  incoming flit
- DCTS  out  1  one-cycle acknowledge to upstream, registered
- Req_N, Req_E, Req_W, Req_S, Req_L  out  1 each  one-hot routing request, registered
- Grant_N, Grant_E, Grant_W, Grant_S, Grant_L  in  1 each  grant from each output arbiter to this port
- dout  out  DATA_W  FIFO head flit; 0 when empty
- empty  out  1  FIFO empty
- occupancy  out  $clog2(DEPTH)+1  stored flit count
- err  out  1  one-cycle protocol-error pulse, registered

Behaviour:
- Reset (clk edge with rst=1): DCTS=0, all Req=0, err=0, pointers=0, occupancy=0, route state=IDLE.
  - An in-flight handshake is abandoned and nothing is written.
- Flit type codes: 3'b001 head, 3'b010 body, 3'b100 tail. Any other code is treated as body.
- Head flit destination fields: dest_x=[COORD_W-1:0], dest_y=[2*COORD_W-1:COORD_W].
- Receive handshake:
  - accept = RTS & !DCTS & (occupancy < DEPTH).
  - On an accept edge, rx_flit is written at wr_ptr and DCTS<=1.
  - On the next edge DCTS<=0 unconditionally, so DCTS is never high for two consecutive cycles.
  - Upstream drops RTS one cycle after seeing DCTS, so each RTS transaction yields exactly one write.
  - Full is evaluated on registered occupancy. A pop in the same cycle does not allow a write; DCTS is delayed one cycle.
- FIFO:
  - Circular buffer; wr_ptr/rd_ptr wrap modulo DEPTH.
  - occupancy +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - empty = (occupancy==0). dout = mem[rd_ptr] when not empty, else 0.
- Route FSM, two states:
  - IDLE: if !empty and the head flit type is head, compute XY routing and go to ACTIVE, registering the one-hot Req. Req appears 1 cycle after the head flit reaches the FIFO head.
    - XY routing order: dest_x>CUR_X→E; dest_x<CUR_X→W; else dest_y<CUR_Y→N; dest_y>CUR_Y→S; else L.
  - IDLE with a non-head flit at the head: pop and discard it, pulse err, stay IDLE.
  - ACTIVE: Req is held constant.
    - pop = !empty & (Grant matching the asserted Req).
    - A Grant on a non-requested direction is ignored and pulses err.
    - When the popped flit is a tail: Req<=0 and go to IDLE on the same edge.
    - A following head flit is requested 1 cycle later, giving one idle cycle between packets.
  - ACTIVE with the FIFO empty: Req stays asserted; a Grant is ignored and no pop occurs.
- Grants with IDLE state: ignored, no err.
- Single-flit packets are not supported; a head must be followed by a tail eventually.

Test Plan:
- Reset, then RTS=1 with a head flit for dest (1,0), CUR=(0,0) → DCTS high exactly 1 cycle after the RTS cycle; occupancy=1; Req_E=1 one cycle after the head is visible; other Reqs 0.
- Stream 4-flit packet head/body/body/tail, DEPTH=4, no grants → 4 DCTS pulses, occupancy=4; a 5th RTS gets no DCTS until a Grant_E pop, then DCTS 1 cycle after that pop; pointers wrap to 0.
- Grant_E held 4 cycles on a full packet → dout sequence head, body, body, tail; Req_E drops at the tail pop edge; empty=1 afterwards.
- Head dest=(0,0) at CUR=(0,0) → Req_L; dest (0,1) → Req_S; dest (0,0) at CUR=(1,1) → Req_W (X resolved first).
- Body flit arrives while IDLE → discarded, err pulses 1 cycle, occupancy returns to 0; Grant_N while Req_E is active → no pop, err pulse.
- rst asserted in the cycle DCTS=1 → DCTS=0, occupancy=0, all Req=0 on the next cycle; RTS held high afterwards → a fresh accept occurs.
